systolic_seq_ctrl: RTL and testbench
====================================

Name: systolic_seq_ctrl

Overview:
Sequencer for the N x N weight-stationary systolic array of MAC PEs.
- On a start command it runs the weight-load phase: broadcast pass enable plus per-column diagonal capture strobes.
- It then streams M activation vectors, drains the pipeline, flags valid output rows and signals completion.
- It sits between the instruction decoder (start/done handshake) and the array, weight buffer and activation buffer.

Parameters:
N, 4, array dimension (rows = columns), >= 2
WADDR_W, 2, weight-buffer address width, >= clog2(N)
VEC_W, 8, width of vector count and activation address

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
start  input  1  command strobe; accepted only in IDLE
load_weights  input  1  sampled with start: 1 = run LOAD first, 0 = reuse resident weights
use_signed_in  input  1  sampled with start: signed MAC mode
num_vec  input  VEC_W  sampled with start: number of activation vectors M
busy  output  1  high from the cycle after start is accepted until DONE
done  output  1  one-cycle pulse in the DONE state
use_signed  output  1  latched mode, held constant for the whole command
wt_rd_en  output  1  weight-buffer read strobe
wt_rd_addr  output  WADDR_W  weight row index k; row k is the weight for PE row N-1-k
en_weight_pass  output  1  broadcast to all PEs
en_weight_capture  output  N  bit c drives every PE in column c
act_rd_en  output  1  activation-buffer read strobe
act_rd_addr  output  VEC_W  activation vector index
out_valid  output  1  bottom-row column-0 psum holds a valid result
out_idx  output  VEC_W  vector index for out_valid

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE. All outputs are 0 and all counters are cleared. Reset mid-command aborts immediately; no done pulse is produced.
- External timing contract:
  - The weight and activation buffers have 1-cycle read latency.
  - External skew registers delay column/row c by c cycles.
  - All controller outputs are registered.
- States: IDLE, LOAD, COMPUTE, DRAIN, DONE.
- IDLE: on start=1, latch load_weights, use_signed_in and num_vec. Next state is LOAD if load_weights=1, else COMPUTE. start outside IDLE is ignored and not queued.
- LOAD lasts exactly 2N cycles, local cycle t = 0..2N-1:
  - wt_rd_en=1 and wt_rd_addr=t for t < N.
  - en_weight_pass=1 for 1 <= t <= 2N-1.
  - en_weight_capture[c]=1 only at t = N+c; exactly one column is captured per cycle.
  - After t=2N-1: next state is COMPUTE, or DONE if M=0.
- COMPUTE lasts M cycles, i = 0..M-1:
  - act_rd_en=1, act_rd_addr=i.
  - en_weight_pass=0 and en_weight_capture=0.
  - With M=0 and load_weights=0, go straight from IDLE to DONE.
- DRAIN lasts exactly 2N cycles after the last COMPUTE cycle. act_rd_en=0. Then go to DONE.
- out_valid=1 exactly at COMPUTE-relative cycles N+1+i for i < M, with out_idx=i. out_valid may span the COMPUTE/DRAIN boundary; it is never asserted in LOAD or IDLE.
- DONE lasts 1 cycle: done=1. busy drops in the same cycle. Next state is IDLE. A new start is accepted the following cycle.
- busy=1 in LOAD, COMPUTE and DRAIN. It is 0 in IDLE and DONE.
- use_signed holds its latched value until the next accepted start; it is not cleared in IDLE.
- Counters: the cycle counter is sized for max(2N, M). M = 2^VEC_W - 1 must work with no wrap; act_rd_addr never exceeds M-1.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with start=1 -> all outputs 0, state IDLE, no done.
- N=4, load_weights=1, M=3:
  - wt_rd_addr 0,1,2,3 on LOAD t=0..3.
  - en_weight_pass high on t=1..7.
  - en_weight_capture = 0001, 0010, 0100, 1000 on t=4..7.
  - act_rd_addr 0,1,2 on COMPUTE cycles 0..2.
  - out_valid on COMPUTE cycles 5,6,7 with out_idx 0,1,2.
  - 8 DRAIN cycles, then done one cycle later; total 2N+M+2N+1 = 20 cycles from IDLE exit to DONE.
- load_weights=0, M=2 -> no wt_rd_en, no en_weight_pass, act reads start the cycle after start, done after 2+8 cycles.
- load_weights=1, M=0 -> full 8-cycle LOAD, then DONE directly; no act_rd_en and no out_valid.
- start pulsed during LOAD and again in the DONE cycle -> both ignored; a start one cycle after DONE is accepted.
- use_signed_in=1 with start, then toggled mid-command -> use_signed stays 1. rst_n=0 in COMPUTE cycle 1 -> next cycle IDLE, all outputs 0, no done.

Source files
------------

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an N x N weight-stationary systolic array: weight load, activation
// streaming, pipeline drain and completion. All outputs are registered.
module systolic_seq_ctrl #(
  parameter int N       = 4,
  parameter int WADDR_W = 2,
  parameter int VEC_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               load_weights,
  input  logic               use_signed_in,
  input  logic [VEC_W-1:0]   num_vec,
  output logic               busy,
  output logic               done,
  output logic               use_signed,
  output logic               wt_rd_en,
  output logic [WADDR_W-1:0] wt_rd_addr,
  output logic               en_weight_pass,
  output logic [N-1:0]       en_weight_capture,
  output logic               act_rd_en,
  output logic [VEC_W-1:0]   act_rd_addr,
  output logic               out_valid,
  output logic [VEC_W-1:0]   out_idx
);

  // Counter spans LOAD (0..2N-1) and COMPUTE+DRAIN (0..M+2N-1) without wrapping.
  localparam int CW = VEC_W + $clog2(2 * N) + 1;
  localparam logic [CW-1:0] N_C       = CW'(N);
  localparam logic [CW-1:0] LAST_LOAD = CW'(2 * N - 1);
  localparam logic [CW-1:0] OV_FIRST  = CW'(N + 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, DONE} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [VEC_W-1:0] m, m_nx;
  logic [CW-1:0]    m_ext, m_nx_ext, ov_rel;
  logic [N-1:0]     cap_n;

  assign m_ext    = {{(CW-VEC_W){1'b0}}, m};
  assign m_nx_ext = {{(CW-VEC_W){1'b0}}, m_nx};
  assign ov_rel   = cnt_n - OV_FIRST;

  // Handshake: start is a one-cycle command strobe honoured only in IDLE; busy covers
  // LOAD/COMPUTE/DRAIN and done pulses for exactly one cycle when the command retires.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    m_nx    = m;
    case (state)
      IDLE: begin
        if (start) begin
          m_nx  = num_vec;
          cnt_n = '0;
          if (load_weights)        state_n = LOAD;
          else if (num_vec == '0)  state_n = DONE;
          else                     state_n = COMPUTE;
        end
      end
      LOAD: begin
        if (cnt == LAST_LOAD) begin
          cnt_n   = '0;
          state_n = (m == '0) ? DONE : COMPUTE;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      COMPUTE: begin
        cnt_n = cnt + ONE;
        if (cnt == m_ext - ONE) state_n = DRAIN;
      end
      DRAIN: begin
        if (cnt == m_ext + LAST_LOAD) state_n = DONE;
        else                          cnt_n   = cnt + ONE;
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    cap_n = '0;
    for (int c = 0; c < N; c++)
      cap_n[c] = (state_n == LOAD) && (cnt_n == N_C + CW'(c));
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      cnt               <= '0;
      m                 <= '0;
      use_signed        <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      wt_rd_en          <= 1'b0;
      wt_rd_addr        <= '0;
      en_weight_pass    <= 1'b0;
      en_weight_capture <= '0;
      act_rd_en         <= 1'b0;
      act_rd_addr       <= '0;
      out_valid         <= 1'b0;
      out_idx           <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      m     <= m_nx;
      if (state == IDLE && start) use_signed <= use_signed_in;
      busy              <= (state_n == LOAD) || (state_n == COMPUTE) || (state_n == DRAIN);
      done              <= (state_n == DONE);
      wt_rd_en          <= (state_n == LOAD) && (cnt_n < N_C);
      wt_rd_addr        <= (state_n == LOAD) && (cnt_n < N_C) ? cnt_n[WADDR_W-1:0] : '0;
      en_weight_pass    <= (state_n == LOAD) && (cnt_n >= ONE);
      en_weight_capture <= cap_n;
      act_rd_en         <= (state_n == COMPUTE);
      act_rd_addr       <= (state_n == COMPUTE) ? cnt_n[VEC_W-1:0] : '0;
      if ((state_n == COMPUTE || state_n == DRAIN) &&
          (cnt_n >= OV_FIRST) && (cnt_n < OV_FIRST + m_nx_ext)) begin
        out_valid <= 1'b1;
        out_idx   <= ov_rel[VEC_W-1:0];
      end else begin
        out_valid <= 1'b0;
        out_idx   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: command table with hand-derived latencies, per-cycle
// window checks and address/index scoreboards, plus reset corner sequences.
module tb_systolic_seq_ctrl;
  localparam int N       = 4;
  localparam int WADDR_W = 2;
  localparam int VEC_W   = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               load_weights;
  logic               use_signed_in;
  logic [VEC_W-1:0]   num_vec;
  logic               busy;
  logic               done;
  logic               use_signed;
  logic               wt_rd_en;
  logic [WADDR_W-1:0] wt_rd_addr;
  logic               en_weight_pass;
  logic [N-1:0]       en_weight_capture;
  logic               act_rd_en;
  logic [VEC_W-1:0]   act_rd_addr;
  logic               out_valid;
  logic [VEC_W-1:0]   out_idx;

  systolic_seq_ctrl #(.N(N), .WADDR_W(WADDR_W), .VEC_W(VEC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_weights(load_weights),
    .use_signed_in(use_signed_in), .num_vec(num_vec), .busy(busy), .done(done),
    .use_signed(use_signed), .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr),
    .en_weight_pass(en_weight_pass), .en_weight_capture(en_weight_capture),
    .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .out_valid(out_valid),
    .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             lw;
    logic             sgn;
    logic [VEC_W-1:0] m;
    int               lat;   // cycles from the accepting edge to the done cycle
    bit               junk;  // drive stray start/mode activity during the command
  } vec_t;

  vec_t vecs[7];
  int n_checks = 0;
  int n_errors = 0;
  logic [VEC_W-1:0] act_q[$];
  logic [VEC_W-1:0] ov_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " busy"}, 32'(busy), 32'(0));
    chk({tag, " done"}, 32'(done), 32'(0));
    chk({tag, " use_signed"}, 32'(use_signed), 32'(0));
    chk({tag, " wt_rd_en"}, 32'(wt_rd_en), 32'(0));
    chk({tag, " wt_rd_addr"}, 32'(wt_rd_addr), 32'(0));
    chk({tag, " en_weight_pass"}, 32'(en_weight_pass), 32'(0));
    chk({tag, " en_weight_capture"}, 32'(en_weight_capture), 32'(0));
    chk({tag, " act_rd_en"}, 32'(act_rd_en), 32'(0));
    chk({tag, " act_rd_addr"}, 32'(act_rd_addr), 32'(0));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(0));
    chk({tag, " out_idx"}, 32'(out_idx), 32'(0));
  endtask

  // Entered just after a posedge in an IDLE cycle; returns just after the DONE->IDLE edge.
  task automatic run_cmd(input vec_t v);
    int base;
    logic [VEC_W-1:0] e;
    logic [31:0] cap_exp;
    base = v.lw ? 2 * N : 0;
    act_q.delete();
    ov_q.delete();
    for (int i = 0; i < int'(v.m); i++) begin
      act_q.push_back(VEC_W'(i));
      ov_q.push_back(VEC_W'(i));
    end
    start = 1'b1; load_weights = v.lw; use_signed_in = v.sgn; num_vec = v.m;
    @(posedge clk);
    for (int cyc = 1; cyc <= v.lat; cyc++) begin
      #1;
      if (v.junk) begin
        start         = (cyc == 2 || cyc == v.lat) ? 1'b1 : 1'($urandom_range(0, 1));
        load_weights  = 1'($urandom_range(0, 1));
        use_signed_in = ~v.sgn;
        num_vec       = VEC_W'($urandom_range(0, 255));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      chk("busy", 32'(busy), 32'(cyc < v.lat));
      chk("done", 32'(done), 32'(cyc == v.lat));
      chk("use_signed", 32'(use_signed), 32'(v.sgn));
      chk("wt_rd_en", 32'(wt_rd_en), 32'(v.lw && cyc <= N));
      if (wt_rd_en) chk("wt_rd_addr", 32'(wt_rd_addr), 32'(cyc - 1));
      chk("en_weight_pass", 32'(en_weight_pass), 32'(v.lw && cyc >= 2 && cyc <= 2 * N));
      cap_exp = (v.lw && cyc > N && cyc <= 2 * N) ? (32'd1 << (cyc - 1 - N)) : 32'd0;
      chk("en_weight_capture", 32'(en_weight_capture), cap_exp);
      chk("act_rd_en", 32'(act_rd_en), 32'(cyc > base && cyc <= base + int'(v.m)));
      if (act_rd_en) begin
        if (act_q.size() == 0) chk("act_q underflow", 32'(1), 32'(0));
        else begin
          e = act_q.pop_front();
          chk("act_rd_addr", 32'(act_rd_addr), 32'(e));
        end
      end
      chk("out_valid", 32'(out_valid),
          32'(cyc >= base + N + 2 && cyc <= base + N + 1 + int'(v.m)));
      if (out_valid) begin
        if (ov_q.size() == 0) chk("ov_q underflow", 32'(1), 32'(0));
        else begin
          e = ov_q.pop_front();
          chk("out_idx", 32'(out_idx), 32'(e));
        end
      end
      @(posedge clk);
    end
    #1;
    start = 1'b0;
    chk("act_q leftover", 32'(act_q.size()), 32'(0));
    chk("ov_q leftover", 32'(ov_q.size()), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{lw: 1'b1, sgn: 1'b0, m: 8'd3,   lat: 20,  junk: 1'b1};
    vecs[1] = '{lw: 1'b0, sgn: 1'b1, m: 8'd2,   lat: 11,  junk: 1'b0};
    vecs[2] = '{lw: 1'b1, sgn: 1'b0, m: 8'd0,   lat: 9,   junk: 1'b0};
    vecs[3] = '{lw: 1'b0, sgn: 1'b0, m: 8'd0,   lat: 1,   junk: 1'b0};
    vecs[4] = '{lw: 1'b0, sgn: 1'b1, m: 8'd1,   lat: 10,  junk: 1'b0};
    vecs[5] = '{lw: 1'b1, sgn: 1'b1, m: 8'd10,  lat: 27,  junk: 1'b1};
    vecs[6] = '{lw: 1'b0, sgn: 1'b0, m: 8'd255, lat: 264, junk: 1'b0};

    // Reset held with start asserted must leave everything quiet.
    rst_n = 1'b0; start = 1'b1; load_weights = 1'b1; use_signed_in = 1'b1; num_vec = 8'd3;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    chk_quiet("post-reset idle");
    @(posedge clk);
    #1;

    // Commands back to back: each start lands in the IDLE cycle right after DONE.
    for (int k = 0; k < 7; k++) run_cmd(vecs[k]);

    @(negedge clk);
    chk("idle after cmds busy", 32'(busy), 32'(0));
    chk("idle after cmds done", 32'(done), 32'(0));
    @(posedge clk);
    #1;

    // Reset in COMPUTE cycle 1 aborts with no done pulse.
    start = 1'b1; load_weights = 1'b0; use_signed_in = 1'b1; num_vec = 8'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort act_rd_en", 32'(act_rd_en), 32'(1));
    chk("abort act_rd_addr", 32'(act_rd_addr), 32'(1));
    chk("abort use_signed", 32'(use_signed), 32'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_quiet("abort");
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort no done", 32'(done), 32'(0));
      chk("abort no busy", 32'(busy), 32'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
